// File: rtl/multdiv_seq.sv
// Iterative signed multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one iteration per cycle, sequenced by a small FSM that drives HI/LO write strobes.
module multdiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             hiwrite,
    output logic             lowrite,
    output logic             divby0
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_SIGN,
        S_DONE,
        S_EXC
    } state_t;

    state_t state, state_next;

    logic             op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             sign_res, sign_a;
    logic [2*WIDTH:0] acc;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mult_sum;
    logic [2*WIDTH:0]   mult_acc;
    logic [WIDTH:0]     rem_sh, rem_new;
    logic               fits;
    logic [2*WIDTH:0]   div_acc;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;

    // Magnitudes; the most negative value wraps to 2^(W-1), which is correct read as unsigned.
    assign abs_a = a_q[WIDTH-1] ? -a_q : a_q;
    assign abs_b = b_q[WIDTH-1] ? -b_q : b_q;

    // Multiply step: mag_b is the multiplier shifting right, acc[2W:W] is the carry-extended upper half.
    assign mult_sum = acc[2*WIDTH:WIDTH] + (mag_b[0] ? {1'b0, mag_a} : '0);
    assign mult_acc = {1'b0, mult_sum, acc[WIDTH-1:1]};

    // Divide step: mag_a is the dividend shifting left, acc holds {rem, quo}.
    assign rem_sh  = {acc[2*WIDTH-1:WIDTH], mag_a[WIDTH-1]};
    assign fits    = rem_sh >= {1'b0, mag_b};
    assign rem_new = fits ? rem_sh - {1'b0, mag_b} : rem_sh;
    assign div_acc = {rem_new, acc[WIDTH-2:0], fits};

    assign prod_s = sign_res ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    assign quo_s  = sign_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_s  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (op_div && (srcb == '0)) ? S_EXC : S_LOAD;
                end
            end
            S_LOAD: state_next = S_RUN;
            S_RUN: begin
                if (cnt == '0) begin
                    state_next = S_SIGN;
                end
            end
            S_SIGN:  state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            S_EXC:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state register only.
    always_comb begin
        busy    = (state != S_IDLE);
        done    = (state == S_DONE) || (state == S_EXC);
        hiwrite = (state == S_DONE);
        lowrite = (state == S_DONE);
        divby0  = (state == S_EXC);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            sign_res <= 1'b0;
            sign_a   <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q <= op_div;
                        a_q  <= srca;
                        b_q  <= srcb;
                    end
                end
                S_LOAD: begin
                    mag_a    <= abs_a;
                    mag_b    <= abs_b;
                    sign_res <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
                    sign_a   <= a_q[WIDTH-1];
                    acc      <= '0;
                    cnt      <= CW'(WIDTH - 1);
                end
                S_RUN: begin
                    if (op_q) begin
                        acc   <= div_acc;
                        mag_a <= mag_a << 1;
                    end else begin
                        acc   <= mult_acc;
                        mag_b <= mag_b >> 1;
                    end
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_SIGN: begin
                    if (op_q) begin
                        hi_out <= rem_s;
                        lo_out <= quo_s;
                    end else begin
                        hi_out <= prod_s[2*WIDTH-1:WIDTH];
                        lo_out <= prod_s[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multdiv_seq.md
Name: multdiv_seq

Overview:
- Iterative signed multiply/divide unit with its own sequencing FSM.
- Serves MULT/DIV for the multicycle control unit: the control unit pulses start and waits on busy/done.
- Drives the HI/LO register write strobes (hiwrite, lowrite) and the divide-by-zero exception flag (divby0).
- One radix-2 iteration per cycle: shift-add for multiply, restoring subtraction for divide.

Parameters:
- WIDTH, 32, operand width. Iteration count = WIDTH. Latency start->done = WIDTH+3 cycles.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- op_div  input  1  0 = MULT, 1 = DIV; sampled with start
- srca  input  WIDTH  multiplicand / dividend (signed); sampled with start
- srcb  input  WIDTH  multiplier / divisor (signed); sampled with start
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- hi_out  output  WIDTH  registered HI result: product[2W-1:W] or remainder
- lo_out  output  WIDTH  registered LO result: product[W-1:0] or quotient
- hiwrite  output  1  one-cycle strobe; HI register loads hi_out
- lowrite  output  1  one-cycle strobe; LO register loads lo_out
- divby0  output  1  one-cycle exception pulse on DIV with srcb == 0

Behaviour:
- Reset (synchronous, any state, including mid-operation):
  - state <- IDLE.
  - busy, done, hiwrite, lowrite, divby0 = 0.
  - hi_out, lo_out, all internal accumulators and counters <- 0.
- States: IDLE, LOAD, RUN, SIGN, DONE, EXC.
- IDLE:
  - start=1 latches op_div, srca, srcb.
  - Next state is EXC if op_div=1 and srcb=0, otherwise LOAD.
  - start=0: remain in IDLE.
  - start in any other state is ignored, including DONE and EXC. Operand changes after the sampling edge are ignored.
- LOAD (1 cycle):
  - Store |srca| and |srcb| as unsigned magnitudes; |-2^(W-1)| = 2^(W-1), which is representable unsigned.
  - Store result sign: sign(a) XOR sign(b), and sign(a) separately for the remainder.
  - Clear the 2W-bit accumulator; iteration counter <- WIDTH-1.
- RUN (WIDTH cycles, counter decrements to 0, then SIGN):
  - MULT: if multiplier LSB is 1, add the multiplicand to the upper half; then shift the accumulator right 1 (carry kept).
  - DIV (restoring): shift {rem, quo} left 1; trial = rem - divisor; if trial >= 0 then rem <- trial and quo[0] <- 1.
- SIGN (1 cycle):
  - MULT: negate the 2W-bit product if the result sign is 1.
  - DIV: negate the quotient if the result sign is 1; negate the remainder if sign(a) is 1.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Load hi_out and lo_out.
- DONE (1 cycle): done = hiwrite = lowrite = 1; next state IDLE.
- EXC (1 cycle): done = divby0 = 1; hiwrite = lowrite = 0; hi_out and lo_out unchanged; next state IDLE.
- Timing: with the start edge as edge 0, done is high in cycle WIDTH+3 (35 for WIDTH=32). EXC done is in cycle 1.
- Overflow: DIV of -2^(W-1) by -1 gives lo = 0x80000000, hi = 0. No exception, no trap.
- Widths: internal magnitudes are W bits unsigned. The product accumulator is 2W+1 bits. The remainder path is W+1 bits for the trial subtract.
- hi_out and lo_out hold their value between operations; they change only in the SIGN state or on reset.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

Test Plan:
1. MULT 7 x -3 (srcb=0xFFFFFFFD) -> cycle 35: done=hiwrite=lowrite=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high cycles 1-35, low at 36.
2. DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); also 7 / -2 -> lo=0xFFFFFFFD, hi=0x00000001.
3. DIV 5 / 0 -> cycle 1: done=divby0=1, hiwrite=lowrite=0, hi/lo keep their prior values; busy low at cycle 2.
4. Corners: MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, divby0=0.
5. Start at cycle 0, extra start pulses and operand changes at cycles 5 and 35 -> only the first operation completes; results reflect the cycle-0 operands; the DONE-cycle start is ignored.
6. Reset asserted at cycle 10 of a MULT -> next cycle: IDLE, busy=0, hi/lo=0, no strobes. A new start then completes correctly at +35.
